fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter SHALL be: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Port SHALL be: clock  input  1  sole clock, all state on rising edge.
REQ-003 Port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: PC_select  input  2  next-PC source from controller (00 PC+4, 01 branch/jal target, 10 jalr target, 11 reserved).
REQ-005 Port SHALL be: redirect_valid  input  1  PC_select/targets valid this cycle for the instruction in execute.
REQ-006 Port SHALL be: PC_target  input  32  PC+immediate target (branch, jal).
REQ-007 Port SHALL be: ALU_result  input  32  jalr target (rs1+imm).
REQ-008 Port SHALL be: imem_req  output  1  instruction-memory read request.
REQ-009 Port SHALL be: imem_addr  output  32  read address, equals PC.
REQ-010 Port SHALL be: imem_ack  input  1  read data valid, meaningful only while imem_req=1.
REQ-011 Port SHALL be: imem_rdata  input  32  read data, sampled when imem_ack=1.
REQ-012 Port SHALL be: instr_valid  output  1  instruction/PC held for decode.
REQ-013 Port SHALL be: instr_ready  input  1  decode accepts instruction.
REQ-014 Port SHALL be: instruction  output  32  registered fetched word.
REQ-015 Port SHALL be: PC  output  32  address of current fetch/held instruction.
REQ-016 Port SHALL be: PC_plus4  output  32  PC+4, combinational from PC.

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD, DISCARD; IDLE is entered only by reset.
REQ-018 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL be stable until imem_ack=1.
REQ-020 On imem_ack in FETCH without redirect, instruction SHALL capture imem_rdata, with instr_valid=1 and state HOLD from the next cycle. Minimum latency: 1 cycle ack-to-valid.
REQ-021 In HOLD, instruction and PC SHALL stay stable while instr_ready=0.
REQ-022 In HOLD with instr_ready=1 and no redirect, PC SHALL become PC+4, instr_valid SHALL become 0 and state SHALL become FETCH.
REQ-023 A redirect (redirect_valid=1, PC_select 01 or 10) SHALL load PC with {PC_target[31:2],2'b00} for 01 or {ALU_result[31:2],2'b00} for 10 on the next edge; PC_select 00 or 11 with redirect_valid SHALL behave as no redirect.
REQ-024 Redirect SHALL have priority over instr_ready and imem_ack in the same cycle.
REQ-025 Redirect in HOLD SHALL clear instr_valid and go to FETCH at the new PC.
REQ-026 Redirect in FETCH with imem_ack=1 the same cycle SHALL drop the returned word and go to FETCH at the new PC.
REQ-027 Redirect in FETCH with imem_ack=0 SHALL go to DISCARD; the new PC is loaded immediately but imem_addr SHALL keep the old address until ack.
REQ-028 In DISCARD, imem_req SHALL stay 1 until imem_ack; the acked word SHALL be dropped and state SHALL go to FETCH. A further redirect in DISCARD SHALL update PC and remain in DISCARD.
REQ-029 instr_valid SHALL never be 1 outside HOLD.
REQ-030 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.

Reset
REQ-031 On reset: state=IDLE, PC=RESET_PC, imem_req=0, instr_valid=0, instruction=32'h0000_0013 (nop).
REQ-032 Reset SHALL abort any state, including DISCARD, and a later imem_ack SHALL be ignored unless in FETCH or DISCARD.

Structure
REQ-033 PC_select encodings and state encodings SHALL be localparams in the shared cpu include file, also used by the controller.
REQ-034 One sub-module SHALL be used: pc_register, a 32-bit enable flop with synchronous reset to RESET_PC.

Verification
REQ-035 Reset, then hold instr_ready=1 with 0-wait ack: PC sequence 0,4,8; instr_valid every second cycle; instruction matches memory.
REQ-036 Ack delayed 3 cycles at PC=0x10: imem_addr=0x10 is held stable and imem_req=1 for 4 cycles, then instr_valid=1.
REQ-037 HOLD with instr_ready=0 for 5 cycles: instruction and PC are unchanged; then ready=1 moves PC to PC+4.
REQ-038 In HOLD at PC=0x20, redirect PC_select=01, PC_target=0x103: instr_valid drops and the next fetch address is 0x100.
REQ-039 In FETCH (no ack), redirect 10 with ALU_result=0x41: DISCARD; the stale ack is dropped; the next fetch address is 0x40 and no instr_valid comes from the stale word.
REQ-040 RESET_PC=32'hFFFF_FFFC, accept one instruction: the next imem_addr is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states,
// and the canonical nop word. Imported by the fetch unit and the controller.
package fetch_unit_pkg;

   localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_JALR   = 2'b10;
   localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      FETCH   = 2'b01,
      HOLD    = 2'b10,
      DISCARD = 2'b11
   } fetch_state_t;

   // Only branch/jal and jalr selects actually move the PC.
   function automatic logic is_redirect(
      input logic       valid,
      input logic [1:0] sel
   );
      return valid && (sel == PC_SEL_BRANCH || sel == PC_SEL_JALR);
   endfunction

endpackage

// File: rtl/pc_register.sv
// 32-bit program counter flop with load enable and synchronous reset.
// Ports: clock, reset (sync, active-high), en (load), d (next PC), q (PC).
module pc_register #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] d,
   output logic [31:0] q
);

   always_ff @(posedge clock) begin
      if (reset)
         q <= RESET_PC;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem reads at PC, holds the word for decode,
// and handles branch/jal/jalr redirects including in-flight read discard.
// Ports: clock/reset; PC_select, redirect_valid, PC_target, ALU_result
// from execute; imem_req/addr/ack/rdata to memory; instr_valid/ready,
// instruction, PC, PC_plus4 to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  PC_select,
   input  logic        redirect_valid,
   input  logic [31:0] PC_target,
   input  logic [31:0] ALU_result,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4
);

   fetch_state_t state, state_next;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        pc_en;
   logic [31:0] pc_next;
   logic        instr_load;
   logic        old_addr_load;
   logic [31:0] old_addr;

   assign PC_plus4 = PC + 32'd4;
   assign redirect = is_redirect(redirect_valid, PC_select);

   // Targets are forced word-aligned.
   assign redirect_pc = (PC_select == PC_SEL_JALR)
                      ? (ALU_result & ~32'h3)
                      : (PC_target  & ~32'h3);

   // While discarding, the outstanding read keeps its original address
   // even though PC already points at the redirect target.
   assign imem_addr = (state == DISCARD) ? old_addr : PC;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clock (clock),
      .reset (reset),
      .en    (pc_en),
      .d     (pc_next),
      .q     (PC)
   );

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      pc_en         = 1'b0;
      pc_next       = PC_plus4;
      instr_load    = 1'b0;
      old_addr_load = 1'b0;
      imem_req      = 1'b0;
      instr_valid   = 1'b0;
      unique case (state)
         IDLE: begin
            state_next = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_en   = 1'b1;
               pc_next = redirect_pc;
               if (!imem_ack) begin
                  old_addr_load = 1'b1;
                  state_next    = DISCARD;
               end
            end else if (imem_ack) begin
               instr_load = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (redirect) begin
               pc_en      = 1'b1;
               pc_next    = redirect_pc;
               state_next = FETCH;
            end else if (instr_ready) begin
               pc_en      = 1'b1;
               state_next = FETCH;
            end
         end
         DISCARD: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_en   = 1'b1;
               pc_next = redirect_pc;
            end
            // The stale read completes on ack; its word is never loaded.
            if (imem_ack)
               state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instruction <= NOP_INSTR;
         old_addr    <= RESET_PC;
      end else begin
         if (instr_load)
            instruction <= imem_rdata;
         if (old_addr_load)
            old_addr <= PC;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential/stall/redirect/discard
// scenarios on one instance, and reset-PC wrap on a second instance.
module tb_fetch_unit;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic [1:0]  PC_select;
   logic        redirect_valid;
   logic [31:0] PC_target;
   logic [31:0] ALU_result;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] PC;
   logic [31:0] PC_plus4;

   logic        b_reset;
   logic        b_imem_req;
   logic [31:0] b_imem_addr;
   logic        b_imem_ack;
   logic [31:0] b_imem_rdata;
   logic        b_instr_valid;
   logic        b_instr_ready;
   logic [31:0] b_instruction;
   logic [31:0] b_PC;
   logic [31:0] b_PC_plus4;

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .PC_select      (PC_select),
      .redirect_valid (redirect_valid),
      .PC_target      (PC_target),
      .ALU_result     (ALU_result),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .PC             (PC),
      .PC_plus4       (PC_plus4)
   );

   fetch_unit #(
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_b (
      .clock          (clock),
      .reset          (b_reset),
      .PC_select      (2'b00),
      .redirect_valid (1'b0),
      .PC_target      (32'h0),
      .ALU_result     (32'h0),
      .imem_req       (b_imem_req),
      .imem_addr      (b_imem_addr),
      .imem_ack       (b_imem_ack),
      .imem_rdata     (b_imem_rdata),
      .instr_valid    (b_instr_valid),
      .instr_ready    (b_instr_ready),
      .instruction    (b_instruction),
      .PC             (b_PC),
      .PC_plus4       (b_PC_plus4)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] addr);
      chk({tag, "_req"},   {31'd0, imem_req}, 32'd1);
      chk({tag, "_addr"},  imem_addr, addr);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
   endtask

   task automatic chk_hold(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
      chk({tag, "_pc"},    PC, pc);
      chk({tag, "_instr"}, instruction, ins);
   endtask

   initial begin
      reset          = 1'b1;
      PC_select      = 2'b00;
      redirect_valid = 1'b0;
      PC_target      = 32'h0;
      ALU_result     = 32'h0;
      imem_ack       = 1'b0;
      imem_rdata     = 32'h0;
      instr_ready    = 1'b0;
      b_reset        = 1'b1;
      b_imem_ack     = 1'b0;
      b_imem_rdata   = 32'h0;
      b_instr_ready  = 1'b0;

      // reset state
      tick();
      tick();
      chk("rst_pc", PC, 32'h0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instruction, 32'h0000_0013);
      chk("rst_pc4", PC_plus4, 32'h4);

      // IDLE -> FETCH
      reset = 1'b0;
      tick();
      chk_fetch("f0", 32'h0);

      // zero-wait streaming with ready held high
      instr_ready = 1'b1;
      imem_ack    = 1'b1;
      imem_rdata  = mem(32'h0);
      tick();
      chk_hold("h0", 32'h0, mem(32'h0));
      tick();
      chk_fetch("f4", 32'h4);
      chk("f4_pc", PC, 32'h4);
      imem_rdata = mem(32'h4);
      tick();
      chk_hold("h4", 32'h4, mem(32'h4));
      tick();
      chk_fetch("f8", 32'h8);
      imem_rdata = mem(32'h8);
      tick();
      chk_hold("h8", 32'h8, mem(32'h8));
      tick();
      chk_fetch("fc", 32'hC);
      imem_rdata = mem(32'hC);
      tick();
      chk_hold("hc", 32'hC, mem(32'hC));
      imem_ack = 1'b0;
      tick();

      // ack delayed 3 cycles at 0x10
      for (int i = 0; i < 4; i++) begin
         chk_fetch("wait10", 32'h10);
         imem_ack   = (i == 3);
         imem_rdata = mem(32'h10);
         instr_ready = 1'b0;
         tick();
      end
      imem_ack = 1'b0;
      chk_hold("h10", 32'h10, mem(32'h10));

      // decode stall for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_hold("stall", 32'h10, mem(32'h10));
      end
      instr_ready = 1'b1;
      tick();
      chk_fetch("f14", 32'h14);
      chk("f14_pc", PC, 32'h14);

      // advance to HOLD at 0x20
      imem_ack = 1'b1;
      for (int a = 32'h14; a < 32'h20; a += 4) begin
         imem_rdata = mem(a);
         tick();
         tick();
      end
      instr_ready = 1'b0;
      imem_rdata  = mem(32'h20);
      tick();
      imem_ack = 1'b0;
      chk_hold("h20", 32'h20, mem(32'h20));

      // redirect in HOLD, misaligned branch target
      redirect_valid = 1'b1;
      PC_select      = 2'b01;
      PC_target      = 32'h103;
      instr_ready    = 1'b1;
      tick();
      chk_fetch("rd_hold", 32'h100);
      chk("rd_hold_pc", PC, 32'h100);

      // reserved select with redirect_valid acts as no redirect
      PC_select   = 2'b11;
      PC_target   = 32'h777;
      ALU_result  = 32'h999;
      imem_ack    = 1'b1;
      imem_rdata  = mem(32'h100);
      instr_ready = 1'b0;
      tick();
      chk_hold("rsvd", 32'h100, mem(32'h100));

      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      imem_ack       = 1'b0;
      tick();
      chk_fetch("f104", 32'h104);

      // jalr redirect in FETCH without ack -> DISCARD
      redirect_valid = 1'b1;
      PC_select      = 2'b10;
      ALU_result     = 32'h41;
      tick();
      redirect_valid = 1'b0;
      chk_fetch("disc", 32'h104);
      chk("disc_pc", PC, 32'h40);
      tick();
      chk_fetch("disc2", 32'h104);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      chk_fetch("post_disc", 32'h40);
      chk("post_disc_instr", instruction, mem(32'h100));
      tick();
      chk_fetch("post_disc2", 32'h40);
      imem_ack   = 1'b1;
      imem_rdata = mem(32'h40);
      instr_ready = 1'b0;
      tick();
      imem_ack = 1'b0;
      chk_hold("h40", 32'h40, mem(32'h40));

      // redirect with ack in the same FETCH cycle drops the word
      instr_ready = 1'b1;
      tick();
      chk_fetch("f44", 32'h44);
      redirect_valid = 1'b1;
      PC_select      = 2'b01;
      PC_target      = 32'h200;
      imem_ack       = 1'b1;
      imem_rdata     = 32'hBAD0_BAD0;
      tick();
      chk_fetch("rd_ack", 32'h200);
      chk("rd_ack_instr", instruction, mem(32'h40));

      // further redirects while discarding
      imem_ack   = 1'b0;
      PC_select  = 2'b10;
      ALU_result = 32'h300;
      tick();
      chk_fetch("dd1", 32'h200);
      chk("dd1_pc", PC, 32'h300);
      PC_select = 2'b01;
      PC_target = 32'h404;
      tick();
      redirect_valid = 1'b0;
      chk_fetch("dd2", 32'h200);
      chk("dd2_pc", PC, 32'h404);

      // reset aborts DISCARD; ack in IDLE is ignored
      reset = 1'b1;
      tick();
      chk("rst2_pc", PC, 32'h0);
      chk("rst2_req", {31'd0, imem_req}, 32'd0);
      chk("rst2_instr", instruction, 32'h0000_0013);
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0;
      chk_fetch("idle_ack", 32'h0);
      chk("idle_ack_instr", instruction, 32'h0000_0013);

      // second instance: PC wraps from 0xFFFFFFFC to 0
      b_reset = 1'b0;
      tick();
      chk("b_addr0", b_imem_addr, 32'hFFFF_FFFC);
      chk("b_req0", {31'd0, b_imem_req}, 32'd1);
      chk("b_pc4", b_PC_plus4, 32'h0);
      b_imem_ack    = 1'b1;
      b_instr_ready = 1'b1;
      b_imem_rdata  = 32'hCAFE_F00D;
      tick();
      b_imem_ack = 1'b0;
      chk("b_valid", {31'd0, b_instr_valid}, 32'd1);
      chk("b_instr", b_instruction, 32'hCAFE_F00D);
      tick();
      chk("b_wrap", b_imem_addr, 32'h0);
      chk("b_wrap_pc", b_PC, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
